// File: rtl/clk_freq_divider.sv
// Programmable clock divider / step-rate generator.
// The output is a registered, glitch-free square wave with a period of
// div_value clk cycles. A value of 0 stops the output and a value of 1 runs at
// the fastest legal period of 2. A new divide value is only loaded at a period
// boundary, so a change never produces a runt pulse. The high phase is
// floor(E/2) cycles and the low phase is the remainder, so low >= high. A
// one-cycle tick marks every rising edge, and a wrapping counter counts the
// rising edges.
module clk_freq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] div_value,
  input  logic             enable,
  input  logic             count_clear,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] div_active,
  output logic [WIDTH-1:0] edge_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_q,      state_d;
  logic [WIDTH-1:0] cnt_q,        cnt_d;
  logic [WIDTH-1:0] div_active_q, div_active_d;
  logic [WIDTH-1:0] edge_count_q, edge_count_d;
  logic             clk_out_q,    clk_out_d;
  logic             tick_q,       tick_d;
  logic             busy_q,       busy_d;

  // Decode of the requested period. These signals are only used to compute
  // next-state values, so no input reaches an output without a register.
  logic             req_valid;
  logic [WIDTH-1:0] req_eff;
  logic [WIDTH-1:0] req_high_m1;
  logic [WIDTH-1:0] act_low_m1;
  logic             start_period;

  // Map the request onto an effective period (1 clamps to 2). Then derive the
  // reload value for the first high phase of a new period and for the low
  // phase of the period now running.
  always_comb begin
    req_valid   = enable && (div_value != '0);
    req_eff     = (div_value == WIDTH'(1)) ? WIDTH'(2) : div_value;
    // req_eff >= 2 whenever it is used, so the high phase is at least 1 cycle.
    req_high_m1 = (req_eff >> 1) - WIDTH'(1);
    // Low phase = E - floor(E/2); this stays >= 1 for every running period.
    act_low_m1  = div_active_q - (div_active_q >> 1) - WIDTH'(1);
  end

  // Phase FSM: the next state, the phase counter reload and the output levels.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clk_out_d    = clk_out_q;
    tick_d       = 1'b0;
    div_active_d = div_active_q;
    start_period = 1'b0;

    case (state_q)
      IDLE: begin
        clk_out_d = 1'b0;
        if (req_valid) begin
          start_period = 1'b1;
        end
      end

      HIGH: begin
        if (cnt_q == '0) begin
          state_d   = LOW;
          clk_out_d = 1'b0;
          cnt_d     = act_low_m1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end

      LOW: begin
        if (cnt_q == '0) begin
          // Period boundary: this is the only point where a new period is
          // loaded, or where the output stops once enable has dropped.
          if (req_valid) begin
            start_period = 1'b1;
          end else begin
            state_d   = IDLE;
            clk_out_d = 1'b0;
            cnt_d     = '0;
          end
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        clk_out_d = 1'b0;
        cnt_d     = '0;
      end
    endcase

    if (start_period) begin
      state_d      = HIGH;
      clk_out_d    = 1'b1;
      tick_d       = 1'b1;
      div_active_d = req_eff;
      cnt_d        = req_high_m1;
    end

    busy_d = (state_d != IDLE);
  end

  // Rising-edge counter. It updates on the same edge that raises tick, so
  // edge_count and tick change together. A clear that arrives with an edge
  // still counts that edge.
  always_comb begin
    edge_count_d = edge_count_q;
    if (tick_d) begin
      edge_count_d = count_clear ? WIDTH'(1) : edge_count_q + WIDTH'(1);
    end else if (count_clear) begin
      edge_count_d = '0;
    end
  end

  // State and output registers, with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      div_active_q <= '0;
      edge_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      busy_q       <= busy_d;
      div_active_q <= div_active_d;
      edge_count_q <= edge_count_d;
    end
  end

  assign clk_out    = clk_out_q;
  assign tick       = tick_q;
  assign busy       = busy_q;
  assign div_active = div_active_q;
  assign edge_count = edge_count_q;

endmodule

// File: tb/tb_clk_freq_divider.sv
// Testbench for clk_freq_divider (WIDTH=8 so the wrap of edge_count can be
// reached). A period/position model predicts every output on every cycle, and
// directed literal checks pin the model to hand-computed values.
module tb_clk_freq_divider;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] div_value;
  logic         enable;
  logic         count_clear;
  logic         clk_out;
  logic         tick;
  logic         busy;
  logic [W-1:0] div_active;
  logic [W-1:0] edge_count;

  always #5 clk = ~clk;

  clk_freq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .div_value   (div_value),
    .enable      (enable),
    .count_clear (count_clear),
    .clk_out     (clk_out),
    .tick        (tick),
    .busy        (busy),
    .div_active  (div_active),
    .edge_count  (edge_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  task automatic check(string name, logic [63:0] actual, logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: each period has a length E and a position 0..E-1. The output is
  // high for positions below floor(E/2). A new period starts only after the
  // last position of the current one (or from idle).
  typedef struct packed {
    bit         run;
    logic [W-1:0] e;
    logic [W-1:0] pos;
    logic [W-1:0] ec;
  } mstate_t;

  mstate_t m = '0;

  function automatic logic [W-1:0] eff(logic [W-1:0] n);
    return (n == 1) ? W'(2) : n;
  endfunction

  function automatic mstate_t model_step(mstate_t s, bit rst, bit en, bit clr,
                                         logic [W-1:0] dv);
    mstate_t n;
    bit start;
    n = s;
    start = 1'b0;
    if (rst) return '0;
    if (s.run) begin
      if (s.pos == s.e - 1) begin
        if (en && dv != 0) start = 1'b1;
        else begin
          n.run = 1'b0;
          n.pos = '0;
        end
      end else begin
        n.pos = s.pos + 1;
      end
    end else if (en && dv != 0) begin
      start = 1'b1;
    end
    if (start) begin
      n.run = 1'b1;
      n.e   = eff(dv);
      n.pos = '0;
      n.ec  = clr ? W'(1) : s.ec + 1;
    end else if (clr) begin
      n.ec = '0;
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_step(m, reset, enable, count_clear, div_value);

  // Per-cycle comparison against the model, sampled away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      check("m_clk_out",    clk_out,    (m.run && (m.pos < (m.e >> 1))) ? 1 : 0);
      check("m_tick",       tick,       (m.run && m.pos == 0) ? 1 : 0);
      check("m_busy",       busy,       m.run ? 1 : 0);
      check("m_div_active", div_active, m.e);
      check("m_edge_count", edge_count, m.ec);
    end
  end

  // Measures one period starting on a tick cycle: it counts the high cycles,
  // then the low cycles while busy. At high cycle chg_at it drives new inputs.
  task automatic measure(string tag, int exp_h, int exp_l, int chg_at,
                         logic [W-1:0] chg_div, bit chg_en);
    int h = 0;
    int l = 0;
    while (clk_out === 1'b1 && h < 1000) begin
      if (h == chg_at) begin
        div_value = chg_div;
        enable    = chg_en;
      end
      h++;
      @(negedge clk);
    end
    while (clk_out === 1'b0 && busy === 1'b1 && l < 1000) begin
      l++;
      @(negedge clk);
    end
    check({tag, "_high"}, h, exp_h);
    check({tag, "_low"}, l, exp_l);
    $display("period %s: high %0d low %0d div_active %0d", tag, h, l, div_active);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    reset = 1'b1; enable = 1'b0; count_clear = 1'b0; div_value = '0;
    repeat (3) @(negedge clk);
    checking = 1'b1;
    check("rst_clk_out", clk_out, 0);
    check("rst_tick", tick, 0);
    check("rst_busy", busy, 0);
    check("rst_div_active", div_active, 0);
    check("rst_edge_count", edge_count, 0);

    // Start at period 10.
    reset = 1'b0; div_value = 10; enable = 1'b1;
    @(negedge clk);
    check("first_tick", tick, 1);
    check("first_div_active", div_active, 10);
    check("first_edge_count", edge_count, 1);
    measure("p10a", 5, 5, -1, 10, 1);
    measure("p10b", 5, 5, -1, 10, 1);
    check("three_edges", edge_count, 3);

    // Change to 4 in the middle of a high phase.
    measure("p10c", 5, 5, 2, 4, 1);
    check("div4_at_edge", div_active, 4);
    measure("p4", 2, 2, 0, 3, 1);
    check("div3_active", div_active, 3);
    measure("p3", 1, 2, 0, 1, 1);
    check("div1_clamped", div_active, 2);
    measure("p1", 1, 1, 0, 8, 1);
    check("div8_active", div_active, 8);

    // Graceful stop: enable drops one cycle into the high phase.
    measure("stop8", 4, 4, 1, 8, 0);
    check("stop_busy", busy, 0);
    check("stop_clk_out", clk_out, 0);
    check("stop_div_hold", div_active, 8);
    check("stop_edges", edge_count, 7);
    repeat (10) @(negedge clk);
    check("stop_no_tick_edges", edge_count, 7);

    // div_value = 0 with enable: remains idle.
    div_value = 0; enable = 1'b1;
    repeat (5) @(negedge clk);
    check("zero_busy", busy, 0);
    check("zero_clk_out", clk_out, 0);

    // Reset during the low phase of a period of 6.
    div_value = 6;
    i = 0;
    while (tick !== 1'b1 && i < 20) begin i++; @(negedge clk); end
    check("p6_tick_seen", tick, 1);
    repeat (4) @(negedge clk);
    check("p6_in_low_clk", clk_out, 0);
    check("p6_in_low_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_clk_out", clk_out, 0);
    check("midrst_tick", tick, 0);
    check("midrst_busy", busy, 0);
    check("midrst_div_active", div_active, 0);
    check("midrst_edge_count", edge_count, 0);
    reset = 1'b0;
    @(negedge clk);
    check("postrst_tick", tick, 1);
    check("postrst_div_active", div_active, 6);
    check("postrst_edge_count", edge_count, 1);

    // Largest period 2^W-1: high 127, low 128.
    div_value = 255;
    measure("p6", 3, 3, -1, 255, 1);
    check("p255_active", div_active, 255);
    measure("p255", 127, 128, 0, 2, 1);
    check("p2_active", div_active, 2);

    // Run up to the edge_count wrap.
    i = 0;
    while (edge_count !== 8'd255 && i < 2000) begin i++; @(negedge clk); end
    check("reach_255", edge_count, 255);
    @(negedge clk);
    @(negedge clk);
    check("wrap_to_0", edge_count, 0);
    check("wrap_tick", tick, 1);
    @(negedge clk);
    count_clear = 1'b1;
    @(negedge clk);
    check("clear_with_tick", edge_count, 1);
    check("clear_with_tick_t", tick, 1);
    count_clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("count_after_clear", edge_count, 2);
    count_clear = 1'b1;
    @(negedge clk);
    check("clear_alone", edge_count, 0);
    check("clear_alone_tick", tick, 0);
    count_clear = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
